// File: rtl/i2c_pkg.sv
// Shared state encoding and quarter-bit constants for the I2C write engine.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP
    } i2cState_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int START_Q = 2;
    localparam int STOP_Q  = 3;

    function automatic logic [1:0] lastQuarter(input int nQuarters);
        return 2'(nQuarters - 1);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit tick divider: counts 0..QDIV-1, pulses qtick_o on the last count, synchronous clear.
module i2c_qtick_gen #(
    parameter int QDIV = 625
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic clear_i,
    output logic qtick_o
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] cnt_q;

    assign qtick_o = (cnt_q == CW'(QDIV - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else if (clear_i || qtick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_write_engine.sv
// Open-drain I2C master write engine: START, NBYTES bytes each with an ACK slot, then STOP.
// Optional macro I2C_ABORT_ON_NACK_EN: a NACKed ACK slot ends the transfer with STOP right away.
module i2c_write_engine
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 20_000,
    parameter int NBYTES   = 3
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [8*NBYTES-1:0] iDATA,
    input  logic                iGO,
    output logic                oBUSY,
    output logic                oDONE,
    output logic                oNACK,
    output logic                I2C_SCLK,
    inout  wire                 I2C_SDAT
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int BCW  = $clog2(NBYTES + 1);
    localparam int SW   = 8 * NBYTES;

    localparam logic [1:0]     START_LAST = lastQuarter(START_Q);
    localparam logic [1:0]     STOP_LAST  = lastQuarter(STOP_Q);
    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(NBYTES - 1);

    i2cState_t      state_q, state_d;
    logic [1:0]     qIdx_q, qIdx_d;
    logic [2:0]     bitCnt_q, bitCnt_d;
    logic [BCW-1:0] byteCnt_q, byteCnt_d;
    logic [SW-1:0]  shift_q, shift_d;
    logic           nack_q, nack_d;
    logic           done_q, done_d;
    logic           scl_q, scl_d;
    logic           sdaLow_q, sdaLow_d;
    logic [1:0]     sdaSync_q;
    logic           qtick;
    logic           abortHit;

    i2c_qtick_gen #(
        .QDIV(QDIV)
    ) u_qtick (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .clear_i(state_q == IDLE),
        .qtick_o(qtick)
    );

`ifdef I2C_ABORT_ON_NACK_EN
    assign abortHit = nack_q;
`else
    assign abortHit = 1'b0;
`endif

    // Bus pins are registered from next-state values so they only move on qtick edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            qIdx_q    <= Q0;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
            shift_q   <= '0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sdaLow_q  <= 1'b0;
            sdaSync_q <= 2'b11;
        end else begin
            state_q   <= state_d;
            qIdx_q    <= qIdx_d;
            bitCnt_q  <= bitCnt_d;
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sdaLow_q  <= sdaLow_d;
            sdaSync_q <= {sdaSync_q[0], I2C_SDAT};
        end
    end

    always_comb begin
        state_d   = state_q;
        qIdx_d    = qIdx_q;
        bitCnt_d  = bitCnt_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        case (state_q)
            IDLE: begin
                // A request landing on the oDONE cycle waits one cycle.
                if (iGO && !done_q) begin
                    state_d   = START;
                    qIdx_d    = Q0;
                    bitCnt_d  = '0;
                    byteCnt_d = '0;
                    shift_d   = iDATA;
                    nack_d    = 1'b0;
                end
            end
            START: begin
                if (qtick) begin
                    if (qIdx_q == START_LAST) begin
                        state_d = BIT;
                        qIdx_d  = Q0;
                    end else begin
                        qIdx_d = qIdx_q + 2'd1;
                    end
                end
            end
            BIT: begin
                if (qtick) begin
                    qIdx_d = qIdx_q + 2'd1;
                    if (qIdx_q == Q3) begin
                        shift_d = shift_q << 1;
                        if (bitCnt_q == 3'd7) begin
                            state_d  = ACK;
                            bitCnt_d = '0;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
            end
            ACK: begin
                if (qtick) begin
                    qIdx_d = qIdx_q + 2'd1;
                    if (qIdx_q == Q1 && sdaSync_q[1]) begin
                        nack_d = 1'b1;
                    end
                    if (qIdx_q == Q3) begin
                        if (byteCnt_q == LAST_BYTE || abortHit) begin
                            state_d = STOP;
                        end else begin
                            state_d   = BIT;
                            byteCnt_d = byteCnt_q + 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (qtick) begin
                    if (qIdx_q == STOP_LAST) begin
                        state_d = IDLE;
                        qIdx_d  = Q0;
                    end else begin
                        qIdx_d = qIdx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_d    = 1'b1;
        sdaLow_d = 1'b0;
        done_d   = (state_q == STOP) && (qIdx_q == STOP_LAST) && qtick;
        case (state_d)
            START: begin
                sdaLow_d = 1'b1;
                scl_d    = (qIdx_d == Q0);
            end
            BIT: begin
                sdaLow_d = ~shift_d[SW-1];
                scl_d    = (qIdx_d == Q1) || (qIdx_d == Q2);
            end
            ACK: begin
                scl_d = (qIdx_d == Q1) || (qIdx_d == Q2);
            end
            STOP: begin
                scl_d    = (qIdx_d != Q0);
                sdaLow_d = (qIdx_d != Q2);
            end
            default: ;
        endcase
    end

    assign oBUSY    = (state_q != IDLE);
    assign oDONE    = done_q;
    assign oNACK    = nack_q;
    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = sdaLow_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Self-checking bench for i2c_write_engine: cycle model of BUSY/DONE/NACK plus a slave that scoreboards bytes.
module tb_i2c_write_engine;

    localparam int QDIV = 4;

    logic        iCLK   = 1'b0;
    logic        iRST_N = 1'b1;
    logic        iGO    = 1'b0;
    logic [23:0] iDATA  = '0;
    logic        oBUSY, oDONE, oNACK, I2C_SCLK;
    wire         I2C_SDAT;
    logic        slaveLow = 1'b0;

    assign I2C_SDAT = slaveLow ? 1'b0 : 1'bz;
    pullup (I2C_SDAT);
    wire sdaLine = (I2C_SDAT === 1'b0) ? 1'b0 : 1'b1;

    i2c_write_engine #(
        .CLK_FREQ(400),
        .I2C_FREQ(25),
        .NBYTES  (3)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iDATA   (iDATA),
        .iGO     (iGO),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .oNACK   (oNACK),
        .I2C_SCLK(I2C_SCLK),
        .I2C_SDAT(I2C_SDAT)
    );

    initial forever #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] expQ[$];
    int  nackByte      = -1;
    int  cyc           = 0;
    bit  mActive       = 0;
    int  doneCyc       = 0;
    bit  expNack       = 0;
    int  acceptCount   = 0;
    int  abandonCount  = 0;
    int  dutDoneCount  = 0;

    // Reference timing model: accept rule, busy window, done cycle and expected NACK.
    always @(negedge iCLK) begin
        bit expDoneNow;
        bit expBusyNow;
        int nSent;
        cyc++;
        if (oDONE === 1'b1) dutDoneCount++;
        if (!iRST_N) begin
            if (mActive) abandonCount++;
            mActive = 0;
            expQ.delete();
            checkOutput("rstBusy", oBUSY, 1'b0);
            checkOutput("rstDone", oDONE, 1'b0);
            checkOutput("rstNack", oNACK, 1'b0);
            checkOutput("rstScl", I2C_SCLK, 1'b1);
            checkOutput("rstSda", sdaLine, 1'b1);
        end else begin
            expDoneNow = mActive && (cyc == doneCyc);
            expBusyNow = mActive && (cyc < doneCyc);
            checkOutput("busy", oBUSY, expBusyNow);
            checkOutput("done", oDONE, expDoneNow);
            if (expDoneNow) begin
                checkOutput("nack", oNACK, expNack);
                checkOutput("bytesLeft", expQ.size(), 0);
                checkOutput("idleScl", I2C_SCLK, 1'b1);
                checkOutput("idleSda", sdaLine, 1'b1);
                mActive = 0;
            end
            if (!mActive && !expDoneNow && iGO === 1'b1) begin
                mActive = 1;
                acceptCount++;
                expNack = (nackByte >= 0) && (nackByte < 3);
                nSent = 3;
`ifdef I2C_ABORT_ON_NACK_EN
                if (expNack) nSent = nackByte + 1;
`endif
                doneCyc = cyc + (2 + nSent * 36 + 3) * QDIV + 1;
                for (int b = 0; b < nSent; b++) expQ.push_back(iDATA[23 - 8*b -: 8]);
            end
        end
    end

    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    bit         inFrame = 0;
    int         frameBit = 0;
    int         byteIdx = 0;
    int         startCount = 0;
    int         stopCount = 0;
    logic [7:0] rxByte = '0;

    // Slave: detects START/STOP, shifts bits on SCL rise, ACKs unless told to NACK this byte.
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            slaveLow = 1'b0;
            inFrame  = 0;
            frameBit = 0;
        end else if (I2C_SCLK && prevScl && sdaLine != prevSda) begin
            if (!sdaLine) begin
                startCount++;
                inFrame  = 1;
                frameBit = 0;
                byteIdx  = 0;
            end else begin
                stopCount++;
                inFrame = 0;
            end
        end else if (inFrame && I2C_SCLK && !prevScl) begin
            if (frameBit < 8) begin
                rxByte = {rxByte[6:0], sdaLine};
                frameBit++;
                if (frameBit == 8) begin
                    checkOutput("rxQueueNonEmpty", expQ.size() > 0, 1'b1);
                    if (expQ.size() > 0) checkOutput("rxByte", rxByte, expQ.pop_front());
                end
            end else if (frameBit == 8) begin
                frameBit = 9;
            end
        end else if (inFrame && !I2C_SCLK && prevScl) begin
            if (frameBit == 8) begin
                slaveLow = (byteIdx != nackByte);
            end else if (frameBit == 9) begin
                slaveLow = 1'b0;
                frameBit = 0;
                byteIdx++;
            end
        end
        prevScl = I2C_SCLK;
        prevSda = sdaLine;
    end

    task automatic applyStimulus(input logic [23:0] data, input int nb);
        nackByte = nb;
        iDATA    = data;
        iGO      = 1'b1;
        @(posedge iCLK); #2;
        iGO = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge iCLK);
            if (oDONE === 1'b1) seen = 1;
        end
        checkOutput("doneWithinBudget", seen, 1'b1);
        @(posedge iCLK); #2;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 iRST_N = 1'b0;
        #2;
        checkOutput("resetBusy", oBUSY, 1'b0);
        checkOutput("resetScl", I2C_SCLK, 1'b1);
        checkOutput("resetSda", sdaLine, 1'b1);
        repeat (3) @(posedge iCLK);
        #2 iRST_N = 1'b1;
        @(posedge iCLK); #2;

        $display("[TB] basic write 34 0C 00");
        applyStimulus(24'h34_0C_00, -1);
        waitDone(600);

        $display("[TB] slave NACKs byte 1");
        applyStimulus(24'hA5_5A_FF, 1);
        waitDone(600);

        $display("[TB] NACK cleared by next accept");
        applyStimulus(24'h1E_81_7F, -1);
        waitDone(600);

        $display("[TB] iGO held high, back-to-back");
        nackByte = -1;
        iDATA    = 24'h12_34_56;
        iGO      = 1'b1;
        @(posedge iCLK); #2;
        iDATA = 24'hDE_AD_BE;
        waitDone(600);
        @(posedge iCLK); #2;
        iDATA = 24'h00_FF_00;
        repeat (10) @(posedge iCLK);
        #2 iGO = 1'b0;
        waitDone(600);

        $display("[TB] reset during bit 5 of byte 2");
        applyStimulus(24'hC3_3C_96, -1);
        repeat (382) @(posedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        checkOutput("midRstScl", I2C_SCLK, 1'b1);
        checkOutput("midRstSda", sdaLine, 1'b1);
        checkOutput("midRstBusy", oBUSY, 1'b0);
        repeat (3) @(posedge iCLK);
        #2 iRST_N = 1'b1;
        @(posedge iCLK); #2;
        applyStimulus(24'h3C_A5_0F, -1);
        waitDone(600);

        $display("[TB] iGO while busy is ignored");
        applyStimulus(24'h55_AA_01, -1);
        repeat (40) @(posedge iCLK);
        #2;
        iDATA = 24'hFF_FF_FF;
        iGO   = 1'b1;
        @(posedge iCLK); #2;
        iGO = 1'b0;
        repeat (100) @(posedge iCLK);
        #2 iGO = 1'b1;
        repeat (5) @(posedge iCLK);
        #2 iGO = 1'b0;
        waitDone(600);
        repeat (5) @(posedge iCLK);
        #2;

        checkOutput("doneCount", dutDoneCount, acceptCount - abandonCount);
        checkOutput("startCount", startCount, acceptCount);
        checkOutput("stopCount", stopCount, dutDoneCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
